mem_req_arbiter: RTL and testbench

// - Sits between a core's miss sources (icache, vector load/store) and the shared memory port.
// - Arbitrates request_t beats round-robin and holds a port locked for a whole multi-beat burst.
// - Registers the winning beat onto mem_req and returns req_grant to the source.
// - Steers each mem_rsp back to its owner using the class in access_id[ACCESS_ID_WIDTH-1:ACCESS_ID_WIDTH-2].

---
 rtl/mem_req_arbiter_if.sv | 35 +++
 rtl/mem_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Request/response beat type and the arbiter bundle shared by sources, memory and arbiter.
`default_nettype none

typedef struct packed {
    logic        vld;
    logic [3:0]  core_id;
    logic [7:0]  access_id;
    logic [5:0]  access_length;
    logic [31:0] addr;
    logic [31:0] data;
} request_t;

interface mem_req_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    request_t             req [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_grant;
    request_t             mem_req;
    logic                 mem_ready;
    request_t             mem_rsp;
    request_t             rsp [NUM_PORTS];
    logic                 rsp_unrouted;

    modport master (
        output req, mem_ready, mem_rsp,
        input  req_grant, mem_req, rsp, rsp_unrouted
    );

    modport slave (
        input  req, mem_ready, mem_rsp,
        output req_grant, mem_req, rsp, rsp_unrouted
    );
endinterface

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// Round-robin, burst-locking memory request arbiter with class-based response steering.
// Optional perf counters (grant_cnt, stall_cnt) enabled by defining ARB_PERF_CNT_EN.
`default_nettype none

module mem_req_arbiter #(
    parameter logic [3:0]             CORE_ID          = 4'd0,
    parameter int                     NUM_PORTS        = 2,
    // class owned by port p lives in PORT_CLASS[2*p +: 2]; port0=01, port1=10
    parameter logic [2*NUM_PORTS-1:0] PORT_CLASS       = 4'b10_01,
    parameter int                     CNT_W            = 32,
    parameter int                     CACHE_BLOCK_SIZE = 32,
    parameter int                     ACCESS_ID_WIDTH  = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_req_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   grant_cnt [NUM_PORTS],
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    localparam int BC_W  = $clog2(CACHE_BLOCK_SIZE) + 1;
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [BC_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [BC_W-1:0]      burst_len_q, burst_len_d;
    request_t             mem_req_q, mem_req_d;
    request_t             rsp_q [NUM_PORTS];
    request_t             rsp_d [NUM_PORTS];
    logic                 unrouted_q, unrouted_d;

    logic                 out_free;
    logic                 found;
    logic                 grant;
    logic [PTR_W-1:0]     sel;
    logic [PTR_W:0]       idx;
    logic [BC_W-1:0]      first_len;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [1:0]           rsp_class;
    logic                 rsp_hit;

    // Arbitration and burst FSM
    always_comb begin
        out_free    = !mem_req_q.vld || bus.mem_ready;
        sel         = '0;
        found       = 1'b0;
        idx         = '0;
        if (state_q == BURST) begin
            sel   = owner_q;
            found = bus.req[owner_q].vld;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                if (idx >= (PTR_W+1)'(NUM_PORTS)) begin
                    idx = idx - (PTR_W+1)'(NUM_PORTS);
                end
                if (!found && bus.req[idx[PTR_W-1:0]].vld) begin
                    sel   = idx[PTR_W-1:0];
                    found = 1'b1;
                end
            end
        end
        grant = out_free && found;

        grant_vec = '0;
        if (grant) begin
            grant_vec[sel] = 1'b1;
        end

        // zero-length bursts behave as single beats
        first_len = (bus.req[sel].access_length == '0) ? BC_W'(1)
                                                       : BC_W'(bus.req[sel].access_length);

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        burst_len_d = burst_len_q;
        if (grant) begin
            if (state_q == IDLE) begin
                rr_ptr_d = (sel == PTR_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
                if (first_len > BC_W'(1)) begin
                    state_d     = BURST;
                    owner_d     = sel;
                    beat_cnt_d  = BC_W'(1);
                    burst_len_d = first_len;
                end
            end else if (beat_cnt_q == burst_len_q - 1'b1) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        mem_req_d = mem_req_q;
        if (out_free) begin
            mem_req_d = grant ? bus.req[sel] : '0;
        end
    end

    // Response steering by access_id class and core_id
    always_comb begin
        rsp_class  = bus.mem_rsp.access_id[ACCESS_ID_WIDTH-1 -: 2];
        rsp_hit    = 1'b0;
        unrouted_d = unrouted_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_d[p] = '0;
            if (bus.mem_rsp.vld && bus.mem_rsp.core_id == CORE_ID &&
                rsp_class == PORT_CLASS[2*p +: 2]) begin
                rsp_d[p] = bus.mem_rsp;
                rsp_hit  = 1'b1;
            end
        end
        if (bus.mem_rsp.vld && !rsp_hit) begin
            unrouted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            burst_len_q <= '0;
            mem_req_q   <= '0;
            rsp_q       <= '{default: '0};
            unrouted_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_len_q <= burst_len_d;
            mem_req_q   <= mem_req_d;
            rsp_q       <= rsp_d;
            unrouted_q  <= unrouted_d;
        end
    end

    assign bus.req_grant    = grant_vec;
    assign bus.mem_req      = mem_req_q;
    assign bus.rsp_unrouted = unrouted_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        assign bus.rsp[p] = rsp_q[p];
    end

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] grant_cnt_q [NUM_PORTS];
    logic [CNT_W-1:0] grant_cnt_d [NUM_PORTS];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: stick at all-ones
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant_cnt_d[p] = grant_cnt_q[p];
            if (grant_vec[p] && grant_cnt_q[p] != '1) begin
                grant_cnt_d[p] = grant_cnt_q[p] + 1'b1;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (mem_req_q.vld && !bus.mem_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '{default: '0};
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf
        assign grant_cnt[p] = grant_cnt_q[p];
    end
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter.
`default_nettype none

module tb_mem_req_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_req_arbiter_if #(.NUM_PORTS(2)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] grant_cnt [2];
    logic [31:0] stall_cnt;
`endif

    mem_req_arbiter #(
        .CORE_ID    (4'd0),
        .NUM_PORTS  (2),
        .PORT_CLASS (4'b10_01)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [5:0] len, input logic [31:0] a);
        bus.req[p]               = '0;
        bus.req[p].vld           = v;
        bus.req[p].access_length = len;
        bus.req[p].addr          = a;
        bus.req[p].data          = a ^ 32'hA5A5_0000;
    endtask

    task automatic send_rsp(input logic [3:0] core, input logic [7:0] aid, input logic [31:0] d);
        bus.mem_rsp         = '0;
        bus.mem_rsp.vld     = 1'b1;
        bus.mem_rsp.core_id = core;
        bus.mem_rsp.access_id = aid;
        bus.mem_rsp.data    = d;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rsp   = '0;
        set_req(0, 1'b0, 6'd0, 32'h0);
        set_req(1, 1'b0, 6'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_vld", bus.mem_req.vld, 1'b0);
        check("rst_grant", bus.req_grant, 2'b00);
        check("rst_unrouted", bus.rsp_unrouted, 1'b0);
        check("rst_rsp0_vld", bus.rsp[0].vld, 1'b0);
        reset = 1'b1;
        tick();

        // Burst lock: port0 32 beats while port1 waits
        set_req(0, 1'b1, 6'd32, 32'h100);
        set_req(1, 1'b1, 6'd1, 32'h200);
        for (int i = 0; i < 32; i++) begin
            #1;
            check("burst_grant", bus.req_grant, 2'b01);
            tick();
            check("burst_addr", bus.mem_req.addr, 32'h100 + i);
            bus.req[0].addr          = 32'h100 + i + 1;
            bus.req[0].access_length = 6'd1;
        end
        bus.req[0].vld = 1'b0;
        #1;
        check("burst_p1_grant", bus.req_grant, 2'b10);
        tick();
        check("burst_p1_addr", bus.mem_req.addr, 32'h200);
        bus.req[1].vld = 1'b0;
        #1;
        check("burst_idle_grant", bus.req_grant, 2'b00);
        tick();
        check("burst_idle_vld", bus.mem_req.vld, 1'b0);

        // Round robin between two single-beat sources
        set_req(0, 1'b1, 6'd1, 32'h300);
        set_req(1, 1'b1, 6'd1, 32'h400);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", bus.req_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_addr", bus.mem_req.addr, (i % 2 == 0) ? 32'h300 : 32'h400);
        end
        bus.req[0].vld = 1'b0;
        bus.req[1].vld = 1'b0;
        tick();

        // Single beat, latency 1
        set_req(0, 1'b1, 6'd1, 32'h40);
        #1;
        check("single_grant", bus.req_grant, 2'b01);
        tick();
        bus.req[0].vld = 1'b0;
        check("single_vld", bus.mem_req.vld, 1'b1);
        check("single_addr", bus.mem_req.addr, 32'h40);
        tick();
        check("single_vld_drop", bus.mem_req.vld, 1'b0);

        // Stall: mem_ready low for 5 cycles
        set_req(1, 1'b1, 6'd1, 32'h80);
        #1;
        check("stall_pre_grant", bus.req_grant, 2'b10);
        tick();
        bus.mem_ready   = 1'b0;
        bus.req[1].addr = 32'h84;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_grant", bus.req_grant, 2'b00);
            check("stall_addr", bus.mem_req.addr, 32'h80);
            check("stall_vld", bus.mem_req.vld, 1'b1);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("stall_release_grant", bus.req_grant, 2'b10);
        tick();
        check("stall_release_addr", bus.mem_req.addr, 32'h84);
        bus.req[1].vld = 1'b0;
        tick();
        check("stall_end_vld", bus.mem_req.vld, 1'b0);
`ifdef ARB_PERF_CNT_EN
        check("perf_stall", stall_cnt, 32'd5);
        check("perf_grant0", grant_cnt[0], 32'd35);
        check("perf_grant1", grant_cnt[1], 32'd5);
`endif

        // Response routing
        send_rsp(4'd0, 8'b01_000011, 32'hDEAD_0001);
        tick();
        check("rt0_rsp0_vld", bus.rsp[0].vld, 1'b1);
        check("rt0_rsp0_data", bus.rsp[0].data, 32'hDEAD_0001);
        check("rt0_rsp1_vld", bus.rsp[1].vld, 1'b0);
        check("rt0_unrouted", bus.rsp_unrouted, 1'b0);
        send_rsp(4'd0, 8'b10_000101, 32'hBEEF_0002);
        tick();
        check("rt1_rsp1_vld", bus.rsp[1].vld, 1'b1);
        check("rt1_rsp1_data", bus.rsp[1].data, 32'hBEEF_0002);
        check("rt1_rsp0_vld", bus.rsp[0].vld, 1'b0);
        send_rsp(4'd0, 8'b11_000000, 32'h1234_5678);
        tick();
        check("rt3_rsp0_vld", bus.rsp[0].vld, 1'b0);
        check("rt3_rsp1_vld", bus.rsp[1].vld, 1'b0);
        check("rt3_unrouted", bus.rsp_unrouted, 1'b1);
        send_rsp(4'd1, 8'b01_000000, 32'h0000_0BAD);
        tick();
        check("rtcore_rsp0_vld", bus.rsp[0].vld, 1'b0);
        bus.mem_rsp = '0;
        tick();
        check("rt_sticky", bus.rsp_unrouted, 1'b1);

        // Reset in the middle of a burst
        set_req(0, 1'b1, 6'd32, 32'h1000);
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.req[0].addr = 32'h1000 + i + 1;
        end
        check("mid_pre_vld", bus.mem_req.vld, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_vld", bus.mem_req.vld, 1'b0);
        check("mid_rst_unrouted", bus.rsp_unrouted, 1'b0);
        bus.req[0].vld = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        set_req(1, 1'b1, 6'd1, 32'h500);
        #1;
        check("mid_p1_grant", bus.req_grant, 2'b10);
        tick();
        check("mid_p1_addr", bus.mem_req.addr, 32'h500);
        check("mid_p1_vld", bus.mem_req.vld, 1'b1);
        bus.req[1].vld = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
